// File: rtl/boron_pkg.sv
// Shared types and constants for the boron core arbiter and its sub-blocks.
package boron_pkg;

  localparam int KEY_W          = 80;
  localparam int TEXT_W         = 64;
  localparam int NUM_ROUNDS_DEF = 26;
  localparam int TIMEOUT_DEF    = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/boron_core_arbiter_if.sv
// Requester-side and core-side handshake bundle of the boron core arbiter.
interface boron_core_arbiter_if;
  import boron_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0][KEY_W-1:0]  req_key;
  logic [1:0][TEXT_W-1:0] req_text;
  logic [1:0]             req_ready;

  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [TEXT_W-1:0]      rsp_text;
  logic                   rsp_error;

  logic                   core_start;
  logic [KEY_W-1:0]       core_key;
  logic [TEXT_W-1:0]      core_text;
  logic                   core_done;
  logic [TEXT_W-1:0]      core_cipher;

  modport slave (
    input  req_valid, req_key, req_text, rsp_ready, core_done, core_cipher,
    output req_ready, rsp_valid, rsp_text, rsp_error, core_start, core_key, core_text
  );

  modport master (
    output req_valid, req_key, req_text, rsp_ready, core_done, core_cipher,
    input  req_ready, rsp_valid, rsp_text, rsp_error, core_start, core_key, core_text
  );

endinterface

// File: rtl/boron_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a grant is taken.
module boron_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  logic last;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (take && (|req)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/boron_core_arbiter.sv
// Front end sharing one block-cipher core between two requesters: round-robin
// grant, one-cycle launch, timeout abort and a held per-requester response.
module boron_core_arbiter
  import boron_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  boron_core_arbiter_if.slave bus,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  generate
    if (TIMEOUT <= NUM_ROUNDS) begin : g_bad_timeout
      $error("boron_core_arbiter: TIMEOUT must exceed NUM_ROUNDS");
    end
  endgenerate

  state_t            state;
  state_t            state_next;
  logic [1:0]        grant;
  logic              gnt_idx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              expire;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic              core_start;
  logic [KEY_W-1:0]  core_key;
  logic [TEXT_W-1:0] core_text;
  logic [TEXT_W-1:0] rsp_text;
  logic              rsp_error;

  boron_rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .take  (state == IDLE),
    .grant (grant)
  );

  // Expiry looks at the post-increment count so the abort response lands
  // exactly TIMEOUT cycles after the launch pulse.
  assign cnt_next = tmo_cnt + 1'b1;
  assign expire   = (cnt_next == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready  = grant;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (bus.core_done || expire) state_next = RESP;
      end
      RESP: begin
        rsp_valid = gnt_idx ? 2'b10 : 2'b01;
        if (bus.rsp_ready[gnt_idx]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // core_done is only looked at in RUN, so a stray or late pulse is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_idx   <= 1'b0;
      tmo_cnt   <= '0;
      core_key  <= '0;
      core_text <= '0;
      rsp_text  <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt_idx   <= grant[1];
            core_key  <= bus.req_key[grant[1]];
            core_text <= bus.req_text[grant[1]];
          end
        end
        ISSUE: tmo_cnt <= '0;
        RUN: begin
          tmo_cnt <= cnt_next;
          if (bus.core_done) begin
            rsp_text  <= bus.core_cipher;
            rsp_error <= 1'b0;
          end else if (expire) begin
            rsp_text  <= '0;
            rsp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_text   = rsp_text;
  assign bus.rsp_error  = rsp_error;
  assign bus.core_start = core_start;
  assign bus.core_key   = core_key;
  assign bus.core_text  = core_text;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_boron_core_arbiter.sv
// Directed bench for boron_core_arbiter with a behavioural cipher core model.
module tb_boron_core_arbiter;
  import boron_pkg::*;

  localparam int NUM_ROUNDS = NUM_ROUNDS_DEF;
  localparam int TIMEOUT    = TIMEOUT_DEF;
  // Core model: done pulse CORE_LAT cycles after the core_start cycle.
  localparam int CORE_LAT   = NUM_ROUNDS + 1;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  boron_core_arbiter_if bus ();

  boron_core_arbiter #(.NUM_ROUNDS(NUM_ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always @(posedge clk) cycle++;

  function automatic logic [63:0] cipher_of(input logic [79:0] k, input logic [63:0] t);
    return {t[31:0], t[63:32]} ^ k[79:16] ^ 64'hC3A5_5A3C_0F1E_2D4B;
  endfunction

  function automatic logic [79:0] mk_key(input int r, input int b);
    return {16'hB000 + 16'(r * 16 + b), 64'h0123_4567_89AB_CDEF + 64'(b * 977 + r * 131)};
  endfunction

  function automatic logic [63:0] mk_text(input int r, input int b);
    return 64'hFEED_0000_0000_0000 | 64'(r * 1000 + b * 7 + 1);
  endfunction

  // Behavioural core: latency core_lat (0 = never finishes).
  int core_lat  = 0;
  int core_cnt  = 0;
  int start_cnt = 0;

  always @(posedge clk) begin
    #1;
    bus.core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.core_done   = 1'b1;
        bus.core_cipher = cipher_of(bus.core_key, bus.core_text);
      end
    end
    if (bus.core_start) begin
      start_cnt++;
      if (core_lat > 0) core_cnt = core_lat;
    end
  end

  // Grant monitor.
  int both_ready = 0;
  int ready_busy = 0;
  int ready_cnt[2] = '{0, 0};
  int grant_log[$];
  int grant_cyc[$];

  always @(negedge clk) begin
    if (bus.req_ready == 2'b11) both_ready++;
    if ((bus.req_ready != 2'b00) && busy) ready_busy++;
    for (int i = 0; i < 2; i++) begin
      if (bus.req_ready[i]) begin
        ready_cnt[i]++;
        grant_log.push_back(i);
        grant_cyc.push_back(cycle);
      end
    end
  end

  // Inputs are driven 2 time units after the edge, outputs sampled at 3.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      settle();
      n++;
      if (bus.rsp_valid != 2'b00) return;
    end
    n = -1;
  endtask

  task automatic release_rsp(input logic [1:0] m);
    bus.rsp_ready = m;
    cyc();
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error: got %b want 0", bus.rsp_error); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
    checks++; if (bus.rsp_text !== 64'h0) begin failures++; $display("FAIL reset_rsp_text: got %h want 0", bus.rsp_text); end
    checks++; if (bus.core_key !== 80'h0) begin failures++; $display("FAIL reset_core_key: got %h want 0", bus.core_key); end
    checks++; if (bus.core_text !== 64'h0) begin failures++; $display("FAIL reset_core_text: got %h want 0", bus.core_text); end
  endtask

  task automatic test_single();
    int n;
    int rdy0;
    int starts;
    logic [63:0] exp;
    core_lat = CORE_LAT;
    apply_reset();
    rdy0   = ready_cnt[0];
    starts = start_cnt;
    exp    = cipher_of(80'h0, 64'h0);
    bus.req_key[0]  = '0;
    bus.req_text[0] = '0;
    bus.req_valid   = 2'b01;
    settle();
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", bus.core_start); end
    wait_rsp(CORE_LAT + 8, n);
    checks++; if (n != CORE_LAT + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", n, CORE_LAT + 1); end
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid); end
    checks++; if (bus.rsp_text !== exp) begin failures++; $display("FAIL single_rsp_text: got %h want %h", bus.rsp_text, exp); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL single_rsp_error: got %b want 0", bus.rsp_error); end
    checks++; if (ready_cnt[0] - rdy0 != 1) begin failures++; $display("FAIL single_ready_count: got %0d want 1", ready_cnt[0] - rdy0); end
    checks++; if (start_cnt - starts != 1) begin failures++; $display("FAIL single_start_count: got %0d want 1", start_cnt - starts); end
    release_rsp(2'b01);
    settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_back_idle: busy=%b want 0", busy); end
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL single_rsp_drop: got %b want 00", bus.rsp_valid); end
  endtask

  task automatic test_contention();
    int blk[2];
    int grants;
    int rsps;
    int base;
    int both0;
    int got;
    int pend_req;
    logic [1:0]  last_ready;
    logic [1:0]  exp_valid;
    logic [63:0] pend_exp;
    core_lat = CORE_LAT;
    apply_reset();
    base   = grant_log.size();
    both0  = both_ready;
    blk    = '{0, 0};
    grants = 0;
    rsps   = 0;
    pend_req = 0;
    pend_exp = '0;
    for (int i = 0; i < 2; i++) begin
      bus.req_key[i]  = mk_key(i, 0);
      bus.req_text[i] = mk_text(i, 0);
    end
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 200 && rsps < 4; c++) begin
      settle();
      last_ready = bus.req_ready;
      for (int i = 0; i < 2; i++) begin
        if (last_ready[i]) begin
          pend_req = i;
          pend_exp = cipher_of(bus.req_key[i], bus.req_text[i]);
          grants++;
        end
      end
      if (bus.rsp_valid != 2'b00) begin
        rsps++;
        exp_valid = (pend_req == 1) ? 2'b10 : 2'b01;
        checks++; if (bus.rsp_valid !== exp_valid) begin failures++; $display("FAIL cont_rsp_valid[%0d]: got %b want %b", rsps, bus.rsp_valid, exp_valid); end
        checks++; if (bus.rsp_text !== pend_exp) begin failures++; $display("FAIL cont_rsp_text[%0d]: got %h want %h", rsps, bus.rsp_text, pend_exp); end
      end
      cyc();
      if (grants >= 4) begin
        bus.req_valid = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (last_ready[i]) begin
            blk[i]++;
            bus.req_key[i]  = mk_key(i, blk[i]);
            bus.req_text[i] = mk_text(i, blk[i]);
          end
        end
      end
    end
    bus.rsp_ready = 2'b00;
    checks++; if (rsps != 4) begin failures++; $display("FAIL cont_rsp_count: got %0d want 4", rsps); end
    for (int k = 0; k < 4; k++) begin
      got = (grant_log.size() > base + k) ? grant_log[base + k] : -1;
      checks++; if (got != (k % 2)) begin failures++; $display("FAIL cont_order[%0d]: got %0d want %0d", k, got, k % 2); end
    end
    got = (grant_cyc.size() > base + 1) ? grant_cyc[base + 1] - grant_cyc[base] : -1;
    checks++; if (got != NUM_ROUNDS + 4) begin failures++; $display("FAIL cont_period: got %0d want %0d", got, NUM_ROUNDS + 4); end
    checks++; if (both_ready != both0) begin failures++; $display("FAIL cont_dual_ready: got %0d cycles want 0", both_ready - both0); end
    checks++; if (ready_busy != 0) begin failures++; $display("FAIL ready_while_busy: got %0d cycles want 0", ready_busy); end
  endtask

  task automatic test_timeout();
    int n;
    core_lat = 0;
    bus.req_key[1]  = mk_key(1, 9);
    bus.req_text[1] = mk_text(1, 9);
    bus.req_valid   = 2'b10;
    settle();
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL tmo_grant: got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(TIMEOUT + 8, n);
    checks++; if (n != TIMEOUT) begin failures++; $display("FAIL tmo_latency: got %0d want %0d", n, TIMEOUT); end
    checks++; if (bus.rsp_valid !== 2'b10) begin failures++; $display("FAIL tmo_rsp_valid: got %b want 10", bus.rsp_valid); end
    checks++; if (bus.rsp_error !== 1'b1) begin failures++; $display("FAIL tmo_rsp_error: got %b want 1", bus.rsp_error); end
    checks++; if (bus.rsp_text !== 64'h0) begin failures++; $display("FAIL tmo_rsp_text: got %h want 0", bus.rsp_text); end
    release_rsp(2'b10);
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    int rdy;
    logic [79:0] key1;
    logic [63:0] txt1;
    logic [63:0] exp1;
    logic [63:0] exp0;
    core_lat = CORE_LAT;
    key1 = mk_key(1, 5);
    txt1 = mk_text(1, 5);
    exp1 = cipher_of(key1, txt1);
    exp0 = cipher_of(mk_key(0, 6), mk_text(0, 6));
    bus.req_key[1]  = key1;
    bus.req_text[1] = txt1;
    bus.req_valid   = 2'b10;
    settle();
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL bp_grant: got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(CORE_LAT + 8, n);
    checks++; if (bus.rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_rsp_valid: got %b want 10", bus.rsp_valid); end
    // Requester 0 becomes pending while requester 1 stalls its response.
    bus.req_key[0]  = mk_key(0, 6);
    bus.req_text[0] = mk_text(0, 6);
    bus.req_valid   = 2'b01;
    rdy = ready_cnt[0] + ready_cnt[1];
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      settle();
      if (bus.rsp_valid !== 2'b10 || bus.rsp_text !== exp1 || bus.rsp_error !== 1'b0 ||
          busy !== 1'b1 || bus.core_key !== key1 || bus.core_text !== txt1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    cyc();
    bus.rsp_ready = 2'b10;
    settle();
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL bp_release_no_grant: got %b want 00", bus.req_ready); end
    checks++; if (ready_cnt[0] + ready_cnt[1] != rdy) begin failures++; $display("FAIL bp_no_grant: got %0d grants want 0", ready_cnt[0] + ready_cnt[1] - rdy); end
    cyc();
    bus.rsp_ready = 2'b00;
    settle();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle_next: busy=%b want 0", busy); end
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL bp_next_grant: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(CORE_LAT + 8, n);
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_req0_valid: got %b want 01", bus.rsp_valid); end
    checks++; if (bus.rsp_text !== exp0) begin failures++; $display("FAIL bp_req0_text: got %h want %h", bus.rsp_text, exp0); end
    release_rsp(2'b01);
  endtask

  task automatic test_reset_mid_run();
    int n;
    int bad;
    logic [63:0] exp;
    core_lat = CORE_LAT;
    bus.req_key[0]  = mk_key(0, 3);
    bus.req_text[0] = mk_text(0, 3);
    bus.req_valid   = 2'b01;
    settle();
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rst_pre_grant: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    for (int k = 0; k < 10; k++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    // Spans the cycle where the abandoned block's late core_done arrives.
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_text !== 64'h0 ||
          bus.rsp_error !== 1'b0 || bus.core_start !== 1'b0 || bus.core_key !== 80'h0 ||
          bus.core_text !== 64'h0 || bus.req_ready !== 2'b00) bad++;
      cyc();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_outputs_clear: got %0d bad cycles want 0", bad); end
    bus.req_key[0]  = mk_key(0, 4);
    bus.req_text[0] = mk_text(0, 4);
    bus.req_key[1]  = mk_key(1, 4);
    bus.req_text[1] = mk_text(1, 4);
    exp = cipher_of(mk_key(0, 4), mk_text(0, 4));
    bus.req_valid = 2'b11;
    settle();
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rst_tie_to_zero: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(CORE_LAT + 8, n);
    checks++; if (bus.rsp_valid !== 2'b01) begin failures++; $display("FAIL rst_after_valid: got %b want 01", bus.rsp_valid); end
    checks++; if (bus.rsp_text !== exp) begin failures++; $display("FAIL rst_after_text: got %h want %h", bus.rsp_text, exp); end
    release_rsp(2'b01);
  endtask

  task automatic test_collision();
    int n;
    logic [63:0] exp;
    core_lat = TIMEOUT - 1;
    bus.req_key[1]  = mk_key(1, 7);
    bus.req_text[1] = mk_text(1, 7);
    exp = cipher_of(mk_key(1, 7), mk_text(1, 7));
    bus.req_valid = 2'b10;
    settle();
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL coll_grant: got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(TIMEOUT + 8, n);
    checks++; if (n != TIMEOUT) begin failures++; $display("FAIL coll_latency: got %0d want %0d", n, TIMEOUT); end
    checks++; if (bus.rsp_valid !== 2'b10) begin failures++; $display("FAIL coll_rsp_valid: got %b want 10", bus.rsp_valid); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL coll_rsp_error: got %b want 0", bus.rsp_error); end
    checks++; if (bus.rsp_text !== exp) begin failures++; $display("FAIL coll_rsp_text: got %h want %h", bus.rsp_text, exp); end
    release_rsp(2'b10);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_key   = '0;
    bus.req_text  = '0;
    bus.rsp_ready = 2'b00;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/boron_core_arbiter.md
BORON_CORE_ARBITER -- requirements
Module: boron_core_arbiter

Interface
REQ-001 Parameter NUM_ROUNDS, default 26: core rounds per block; sets the expected core latency.
REQ-002 Parameter TIMEOUT, default 40: cycles allowed from core_start to core_done before abort; SHALL be greater than NUM_ROUNDS.
REQ-003 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports req_valid[i], i=0..1  input  1 each  requester i has a block pending.
REQ-006 Ports req_key[i]  input  80 each  requester i key; req_text[i]  input  64 each  requester i plaintext.
REQ-007 Ports req_ready[i]  output  1 each  request i accepted this cycle.
REQ-008 Ports rsp_valid[i]  output  1 each  result for requester i available; rsp_ready[i]  input  1 each  requester i takes the result.
REQ-009 Ports rsp_text  output  64  ciphertext; rsp_error  output  1  result aborted on timeout. Both are shared by the two requesters.
REQ-010 Ports core_start  output  1  one-cycle launch pulse; core_key  output  80; core_text  output  64.
REQ-011 Ports core_done  input  1  core completion pulse; core_cipher  input  64  core result.
REQ-012 Port busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, ISSUE, RUN, RESP.
- IDLE: if any req_valid, grant per REQ-014, pulse req_ready[g] for one cycle, latch key/text, go to ISSUE.
REQ-014 Arbitration is round-robin with a 1-bit last-grant pointer.
- If both requesters are valid, the one not granted last wins.
- If only one is valid, it wins.
- The pointer updates only on grant.
REQ-015 ISSUE: assert core_start for exactly one cycle with latched core_key/core_text, clear the timeout counter, go to RUN.
REQ-016 core_key and core_text SHALL hold the latched values stable from ISSUE until RESP is exited.
REQ-017 RUN: the timeout counter increments each cycle.
- core_done=1: latch core_cipher into rsp_text, rsp_error=0, go to RESP.
- Counter reaches TIMEOUT-1 without core_done: rsp_text=0, rsp_error=1, go to RESP.
REQ-018 If core_done and timeout expiry occur in the same cycle, core_done wins (rsp_error=0).
REQ-019 RESP: assert rsp_valid[g] only for the granted requester; rsp_text and rsp_error stay stable.
- On rsp_valid[g] and rsp_ready[g]: go to IDLE.
- No new grant is issued in that same cycle.
REQ-020 core_done outside RUN SHALL be ignored; it SHALL NOT alter rsp_text or state.
REQ-021 Nominal latency: grant at cycle T, core_start at T+1, result valid the cycle after core_done.
- Minimum grant-to-grant period with an ideal core and immediate rsp_ready is NUM_ROUNDS+4 cycles.
REQ-022 req_ready[i] SHALL never be high outside IDLE, and never for both requesters in the same cycle.
REQ-023 A requester SHALL hold req_valid, req_key and req_text until req_ready; the arbiter samples them only in the grant cycle.

Reset
REQ-024 reset=1 at a clock edge SHALL, regardless of state:
- go to IDLE;
- clear req_ready, rsp_valid, rsp_error, core_start and busy;
- zero rsp_text, core_key, core_text and the timeout counter;
- set the last-grant pointer so requester 0 wins the first tie.
REQ-025 Reset during RUN abandons the in-flight block; a later core_done from it SHALL be ignored per REQ-020.

Structure
REQ-026 A shared package boron_pkg SHALL hold:
- the state enumeration;
- KEY_W=80, TEXT_W=64;
- the default NUM_ROUNDS and TIMEOUT constants.
REQ-027 A single sub-module, boron_rr_arb2, SHALL implement the 2-way round-robin grant with pointer; everything else stays in boron_core_arbiter.

Verification
REQ-028 Single request: after reset, req_valid[0] with key 0, text 0, model core done after 26 cycles -> exactly one req_ready[0]; one core_start the next cycle; rsp_valid[0] with rsp_text equal to the core output and rsp_error=0.
REQ-029 Contention: both valid continuously for 4 blocks -> grant order 0,1,0,1; never two req_ready in the same cycle.
REQ-030 Timeout: core never asserts done -> rsp_valid[g] with rsp_error=1 and rsp_text=0 exactly TIMEOUT cycles after core_start.
REQ-031 Backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid[1] and rsp_text stay stable, no new grant; release -> IDLE the next cycle.
REQ-032 Reset mid-RUN at cycle 10 of 26, then a late core_done -> outputs at reset values, state IDLE, late done ignored, next tie won by requester 0.
REQ-033 Done/timeout collision: core_done in the expiry cycle -> rsp_error=0 and rsp_text equals core_cipher.
